// File: rtl/divider.sv
// Sequential restoring divider: one quotient bit per clock behind a valid/ready handshake.
// Define DIVIDER_SIGNED_EN for two's-complement truncating division (C semantics).
module divider #(
  parameter int IN_DATA_WIDTH  = 32,
  parameter int OUT_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_DATA_WIDTH-1:0]  dividend,
  input  logic [IN_DATA_WIDTH-1:0]  divisor,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_DATA_WIDTH-1:0] quotient,
  output logic [OUT_DATA_WIDTH-1:0] remainder,
  output logic                      div_by_zero
);
  localparam int W  = IN_DATA_WIDTH;
  localparam int CW = $clog2(W);

  if (OUT_DATA_WIDTH != IN_DATA_WIDTH) begin : g_width_chk
    $error("divider: OUT_DATA_WIDTH must equal IN_DATA_WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic          accept, zero_dsr;
  logic [W-1:0]  dvd, dsr, rem, rem_nxt;
  logic [W-1:0]  dividend_mag, divisor_mag, q_fix, r_fix;
  logic [W:0]    shifted, diff;
  logic          q_bit, last;
  logic [CW-1:0] cnt;

  assign accept   = in_valid & in_ready;
  assign zero_dsr = (divisor == '0);

  // dvd doubles as the quotient register: dividend bits leave at the top while
  // quotient bits enter at the bottom.
  assign shifted = {rem, dvd[W-1]};
  assign diff    = shifted - {1'b0, dsr};
  assign q_bit   = ~diff[W];
  assign rem_nxt = q_bit ? diff[W-1:0] : shifted[W-1:0];

`ifdef DIVIDER_SIGNED_EN
  logic q_neg, r_neg;

  always_comb begin
    dividend_mag = dividend[W-1] ? (~dividend + 1'b1) : dividend;
    divisor_mag  = divisor[W-1]  ? (~divisor + 1'b1)  : divisor;
    q_fix        = q_neg ? (~dvd + 1'b1) : dvd;
    r_fix        = r_neg ? (~rem + 1'b1) : rem;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (state == IDLE && accept) begin
      q_neg <= dividend[W-1] ^ divisor[W-1];
      r_neg <= dividend[W-1];
    end
  end
`else
  always_comb begin
    dividend_mag = dividend;
    divisor_mag  = divisor;
    q_fix        = dvd;
    r_fix        = rem;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = zero_dsr ? DONE : CALC;
      CALC: if (last) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = rst_n;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // The last iteration only raises 'last'; the following edge publishes the
  // (sign-fixed) result, giving W+1 cycles from accept to out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd         <= '0;
      dsr         <= '0;
      rem         <= '0;
      cnt         <= '0;
      last        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          if (zero_dsr) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else begin
            dvd         <= dividend_mag;
            dsr         <= divisor_mag;
            rem         <= '0;
            cnt         <= CW'(W - 1);
            last        <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        CALC: begin
          if (last) begin
            quotient  <= q_fix;
            remainder <= r_fix;
            last      <= 1'b0;
          end else begin
            dvd <= {dvd[W-2:0], q_bit};
            rem <= rem_nxt;
            if (cnt == '0) last <= 1'b1;
            else           cnt  <= cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider (W=32); signed vectors run when DIVIDER_SIGNED_EN is defined.
module tb_divider;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int failures = 0;

  divider #(.IN_DATA_WIDTH(32), .OUT_DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Offer one operand pair, then wait (bounded) for out_valid. lat counts
  // rising edges after the accept edge; the DUT is left in DONE.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic z, output int lat, output logic rdy_seen);
    @(negedge clk);
    in_valid = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    in_valid = 1'b0; dividend = $urandom; divisor = $urandom;
    lat = 0; rdy_seen = 1'b0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (in_ready !== 1'b0) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    q = quotient; r = remainder; z = div_by_zero;
  endtask

  task automatic pop(output logic rdy_after, output logic vld_after);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    rdy_after = in_ready;
    vld_after = out_valid;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (quotient !== 32'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      failures++; $display("FAIL rst_outputs got q=%h r=%h z=%b exp 0/0/0", quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL idle_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic;
    logic [31:0] q, r; logic z, rs, ra, va; int lat;
    do_op(32'd100, 32'd7, q, r, z, lat, rs);
    checks++; if (lat !== 33) begin failures++; $display("FAIL lat_100_7 got=%0d exp=33", lat); end
    checks++; if (rs !== 1'b0) begin failures++; $display("FAIL busy_in_ready got=%b exp=0", rs); end
    checks++; if (q !== 32'd14 || r !== 32'd2 || z !== 1'b0) begin
      failures++; $display("FAIL div_100_7 got q=%0d r=%0d z=%b exp 14/2/0", q, r, z);
    end
    pop(ra, va);
    checks++; if (ra !== 1'b1 || va !== 1'b0) begin failures++; $display("FAIL pop_100_7 got rdy=%b vld=%b exp 1/0", ra, va); end
  endtask

  task automatic test_div_by_zero;
    logic [31:0] q, r; logic z, rs, ra, va; int lat;
    do_op(32'd5, 32'd0, q, r, z, lat, rs);
    // DONE is entered on the accept edge itself
    checks++; if (lat !== 0) begin failures++; $display("FAIL lat_div0 got=%0d exp=0", lat); end
    checks++; if (q !== 32'hFFFF_FFFF || r !== 32'd5 || z !== 1'b1) begin
      failures++; $display("FAIL div0 got q=%h r=%h z=%b exp ffffffff/5/1", q, r, z);
    end
    pop(ra, va);
  endtask

  task automatic test_extremes;
    logic [31:0] q, r; logic z, rs, ra, va; int lat;
    do_op(32'hFFFF_FFFF, 32'd1, q, r, z, lat, rs);
    checks++; if (q !== 32'hFFFF_FFFF || r !== 32'd0 || z !== 1'b0) begin
      failures++; $display("FAIL max_div_1 got q=%h r=%h z=%b exp ffffffff/0/0", q, r, z);
    end
    pop(ra, va);
    do_op(32'd3, 32'hFFFF_FFFF, q, r, z, lat, rs);
`ifdef DIVIDER_SIGNED_EN
    checks++; if (q !== 32'hFFFF_FFFD || r !== 32'd0) begin
      failures++; $display("FAIL three_div_m1 got q=%h r=%h exp fffffffd/0", q, r);
    end
`else
    checks++; if (q !== 32'd0 || r !== 32'd3) begin
      failures++; $display("FAIL three_div_max got q=%h r=%h exp 0/3", q, r);
    end
    checks++; if (lat !== 33) begin failures++; $display("FAIL lat_small got=%0d exp=33", lat); end
`endif
    pop(ra, va);
    do_op(32'd0, 32'd5, q, r, z, lat, rs);
    checks++; if (q !== 32'd0 || r !== 32'd0 || z !== 1'b0) begin
      failures++; $display("FAIL zero_div_5 got q=%h r=%h z=%b exp 0/0/0", q, r, z);
    end
    pop(ra, va);
    do_op(32'd1000, 32'd10, q, r, z, lat, rs);
    checks++; if (q !== 32'd100 || r !== 32'd0) begin
      failures++; $display("FAIL div_1000_10 got q=%0d r=%0d exp 100/0", q, r);
    end
    pop(ra, va);
  endtask

  task automatic test_backpressure;
    logic [31:0] q, r; logic z, rs, ra, va; int lat;
    do_op(32'd100, 32'd7, q, r, z, lat, rs);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || quotient !== 32'd14 || remainder !== 32'd2 || div_by_zero !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_%0d got v=%b q=%0d r=%0d z=%b rdy=%b exp 1/14/2/0/0", i, out_valid, quotient, remainder, div_by_zero, in_ready);
      end
      in_valid = $urandom_range(0, 1); dividend = $urandom; divisor = $urandom;
      @(negedge clk);
    end
    in_valid = 1'b0;
    pop(ra, va);
    checks++; if (ra !== 1'b1 || va !== 1'b0) begin failures++; $display("FAIL bp_release got rdy=%b vld=%b exp 1/0", ra, va); end
  endtask

  task automatic test_reset_mid_calc;
    logic [31:0] q, r; logic z, rs; int lat;
    @(negedge clk);
    in_valid = 1'b1; dividend = 32'd1234; divisor = 32'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = $urandom_range(0, 1); dividend = $urandom; divisor = $urandom;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++; $display("FAIL midrst_hs got rdy=%b vld=%b exp 0/0", in_ready, out_valid);
    end
    checks++; if (quotient !== 32'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0) begin
      failures++; $display("FAIL midrst_outputs got q=%h r=%h z=%b exp 0/0/0", quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    do_op(32'd9, 32'd3, q, r, z, lat, rs);
    checks++; if (q !== 32'd3 || r !== 32'd0 || z !== 1'b0 || lat !== 33) begin
      failures++; $display("FAIL div_9_3 got q=%0d r=%0d z=%b lat=%0d exp 3/0/0/33", q, r, z, lat);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

`ifdef DIVIDER_SIGNED_EN
  task automatic test_signed;
    logic [31:0] q, r; logic z, rs, ra, va; int lat;
    do_op(32'hFFFF_FFF9, 32'd2, q, r, z, lat, rs);
    checks++; if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF || lat !== 33) begin
      failures++; $display("FAIL sdiv_m7_2 got q=%h r=%h lat=%0d exp fffffffd/ffffffff/33", q, r, lat);
    end
    pop(ra, va);
    do_op(32'd7, 32'hFFFF_FFFE, q, r, z, lat, rs);
    checks++; if (q !== 32'hFFFF_FFFD || r !== 32'd1) begin
      failures++; $display("FAIL sdiv_7_m2 got q=%h r=%h exp fffffffd/1", q, r);
    end
    pop(ra, va);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, q, r, z, lat, rs);
    checks++; if (q !== 32'h8000_0000 || r !== 32'd0 || z !== 1'b0) begin
      failures++; $display("FAIL sdiv_ovf got q=%h r=%h z=%b exp 80000000/0/0", q, r, z);
    end
    pop(ra, va);
  endtask
`else
  task automatic test_unsigned_big;
    logic [31:0] q, r; logic z, rs, ra, va; int lat;
    do_op(32'h8000_0000, 32'hFFFF_FFFF, q, r, z, lat, rs);
    checks++; if (q !== 32'd0 || r !== 32'h8000_0000) begin
      failures++; $display("FAIL udiv_small got q=%h r=%h exp 0/80000000", q, r);
    end
    pop(ra, va);
    do_op(32'hFFFF_FFF9, 32'd2, q, r, z, lat, rs);
    checks++; if (q !== 32'h7FFF_FFFC || r !== 32'd1) begin
      failures++; $display("FAIL udiv_big got q=%h r=%h exp 7ffffffc/1", q, r);
    end
    pop(ra, va);
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_div_by_zero;
    test_extremes;
    test_backpressure;
    test_reset_mid_calc;
`ifdef DIVIDER_SIGNED_EN
    test_signed;
`else
    test_unsigned_big;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
